// File: rtl/btb_pkg.sv
// btb_pkg: shared types and PC field helpers for the branch target buffer.
package btb_pkg;
  localparam int idx_w = 6;
  localparam int tag_w = 32 - idx_w - 2;
  typedef enum logic {INIT, READY} btb_state_t;
  typedef struct packed {
    logic valid;
    logic [idx_w-1:0] set;
    logic [tag_w-1:0] tag;
    logic [31:0] target;
    logic taken;
    logic hit;
    logic way;
  } btb_upd_t;
  function automatic logic [idx_w-1:0] get_set(input logic [31:0] pc);
    return pc[idx_w+1:2];
  endfunction
  function automatic logic [tag_w-1:0] get_tag(input logic [31:0] pc);
    return pc[31:idx_w+2];
  endfunction
endpackage

// File: rtl/btb_ctrl_if.sv
// btb_ctrl_if: IF-stage lookup, EX-stage update and flush/ready signals of the BTB.
interface btb_ctrl_if #(parameter int width = 32);
  logic flush;
  logic ready;
  logic lookup_read;
  logic [31:0] lookup_pc;
  logic hit;
  logic hit_way;
  logic [width-1:0] pred_target;
  logic upd_valid;
  logic [31:0] upd_pc;
  logic [width-1:0] upd_target;
  logic upd_taken;
  logic upd_hit;
  logic upd_way;
  modport master (
    output flush, lookup_read, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_hit, upd_way,
    input ready, hit, hit_way, pred_target
  );
  modport slave (
    input flush, lookup_read, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_hit, upd_way,
    output ready, hit, hit_way, pred_target
  );
endinterface

// File: rtl/btb_col.sv
// btb_col: unreset storage column, one write port, combinational read with write-through bypass.
module btb_col #(
  parameter int width = 1,
  parameter int addr_width = 6
) (
  input  logic clk,
  input  logic we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0] wdata,
  input  logic re,
  input  logic [addr_width-1:0] raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem [2**addr_width];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = !re ? '0 : (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/btb_way.sv
// btb_way: valid, tag and target columns of one BTB way plus its tag comparator.
module btb_way #(
  parameter int idx_width = 6,
  parameter int tag_width = 24,
  parameter int width = 32
) (
  input  logic clk,
  input  logic we_valid,
  input  logic we_tag,
  input  logic we_target,
  input  logic [idx_width-1:0] waddr,
  input  logic wvalid,
  input  logic [tag_width-1:0] wtag,
  input  logic [width-1:0] wtarget,
  input  logic re,
  input  logic [idx_width-1:0] raddr,
  input  logic [tag_width-1:0] rtag,
  output logic match,
  output logic [width-1:0] target
);
  logic valid;
  logic [tag_width-1:0] tag;
  btb_col #(.width(1), .addr_width(idx_width)) u_valid (
    .clk(clk), .we(we_valid), .waddr(waddr), .wdata(wvalid), .re(re), .raddr(raddr), .rdata(valid)
  );
  btb_col #(.width(tag_width), .addr_width(idx_width)) u_tag (
    .clk(clk), .we(we_tag), .waddr(waddr), .wdata(wtag), .re(re), .raddr(raddr), .rdata(tag)
  );
  btb_col #(.width(width), .addr_width(idx_width)) u_target (
    .clk(clk), .we(we_target), .waddr(waddr), .wdata(wtarget), .re(re), .raddr(raddr), .rdata(target)
  );
  assign match = valid & (tag == rtag);
endmodule

// File: rtl/btb_ctrl.sv
// btb_ctrl: 2-way BTB sequencing -- init/flush walk, pending update pipeline, lookup and per-set LRU.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int idx_width = idx_w,
  parameter int tag_width = tag_w,
  parameter int width = 32
) (
  input logic clk,
  input logic rst,
  btb_ctrl_if.slave bus
);
  localparam int n_set = 2 ** idx_width;
  btb_state_t state;
  btb_upd_t pend;
  logic [idx_width-1:0] init_idx, look_set;
  logic [tag_width-1:0] look_tag;
  logic [n_set-1:0] lru;
  logic walking, look_re, victim, fill, retarget, kill, lru_val;
  logic [1:0] match;
  logic [width-1:0] target [2];
  assign walking = state == INIT;
  assign look_re = bus.lookup_read & bus.ready;
  assign look_set = get_set(bus.lookup_pc);
  assign look_tag = get_tag(bus.lookup_pc);
  assign victim = lru[pend.set];
  assign fill = ~walking & pend.valid & ~pend.hit & pend.taken;
  assign retarget = ~walking & pend.valid & pend.hit & pend.taken;
  assign kill = ~walking & pend.valid & pend.hit & ~pend.taken;
  assign lru_val = ~(pend.hit ? pend.way : victim);
  // The walker owns the write port in INIT; the pending update owns it in READY.
  for (genvar w = 0; w < 2; w++) begin : g_way
    logic sel;
    assign sel = (pend.hit ? pend.way : victim) == 1'(w);
    btb_way #(.idx_width(idx_width), .tag_width(tag_width), .width(width)) u_way (
      .clk(clk),
      .we_valid(walking | (sel & (fill | kill))),
      .we_tag(sel & fill),
      .we_target(sel & (fill | retarget)),
      .waddr(walking ? init_idx : pend.set),
      .wvalid(fill),
      .wtag(pend.tag),
      .wtarget(pend.target),
      .re(look_re),
      .raddr(look_set),
      .rtag(look_tag),
      .match(match[w]),
      .target(target[w])
    );
  end
  assign bus.hit = |match;
  assign bus.hit_way = match == 2'b10;
  assign bus.pred_target = match[0] ? target[0] : match[1] ? target[1] : '0;
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state <= INIT;
      init_idx <= '0;
      bus.ready <= 1'b0;
      lru <= '0;
      pend <= '0;
    end else begin
      if (walking) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == idx_width'(n_set - 1)) begin
          state <= READY;
          bus.ready <= 1'b1;
        end
      end
      if (bus.hit) lru[look_set] <= ~bus.hit_way;
      // Later assignment: an update's LRU value beats a same-set lookup hit.
      if (fill | retarget) lru[pend.set] <= lru_val;
      pend <= '{valid: bus.upd_valid & ~walking, set: get_set(bus.upd_pc), tag: get_tag(bus.upd_pc),
                target: bus.upd_target, taken: bus.upd_taken, hit: bus.upd_hit, way: bus.upd_way};
    end
  end
  a_one_way_hit: assert property (@(posedge clk) disable iff (rst) !(&match));
endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: random and directed stimulus against an array-based BTB reference model.
module tb_btb_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  btb_ctrl_if bus ();
  btb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  bit mv [64][2];
  bit [23:0] mt [64][2];
  bit [31:0] mg [64][2];
  bit ml [64];
  int init_left;
  bit pv, ph, pw, pk;
  bit [31:0] ppc, ptg;
  int tests, fails;
  bit obs_hit, obs_way;
  logic [31:0] obs_tgt;
  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction
  function automatic bit [23:0] tag_of(input logic [31:0] pc);
    return 24'(pc >> 8);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_model();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0;
      mv[s][1] = 0;
      ml[s] = 0;
    end
    pv = 0;
    init_left = 64;
  endtask
  // One clock: drive, check outputs mid-cycle, then advance the model past the rising edge.
  task automatic step(input bit fl, input bit lr, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input logic [31:0] utg, input bit utk);
    int s, ls, us;
    bit ch, cw, m0, m1, eh, ew, rdy, uh, uw, vw;
    logic [31:0] et;
    ch = 0;
    cw = 0;
    s = 0;
    rdy = init_left == 0;
    if (pv) begin
      s = set_of(ppc);
      if (ph && pk) begin
        mg[s][pw] = ptg;
        ch = 1;
        cw = !pw;
      end else if (ph) mv[s][pw] = 0;
      else if (pk) begin
        vw = ml[s];
        mv[s][vw] = 1;
        mt[s][vw] = tag_of(ppc);
        mg[s][vw] = ptg;
        ch = 1;
        cw = !vw;
      end
      pv = 0;
    end
    ls = set_of(lpc);
    m0 = mv[ls][0] && mt[ls][0] == tag_of(lpc);
    m1 = mv[ls][1] && mt[ls][1] == tag_of(lpc);
    eh = lr && rdy && (m0 || m1);
    ew = eh && !m0;
    et = eh ? mg[ls][ew] : 32'h0;
    us = set_of(upc);
    uh = (mv[us][0] && mt[us][0] == tag_of(upc)) || (mv[us][1] && mt[us][1] == tag_of(upc));
    uw = uh && !(mv[us][0] && mt[us][0] == tag_of(upc));
    bus.flush = fl;
    bus.lookup_read = lr;
    bus.lookup_pc = lpc;
    bus.upd_valid = uv;
    bus.upd_pc = upc;
    bus.upd_target = utg;
    bus.upd_taken = utk;
    bus.upd_hit = uh;
    bus.upd_way = uw;
    #1;
    check("ready", bus.ready, rdy);
    check("hit", bus.hit, eh);
    check("hit_way", bus.hit_way, ew);
    check("pred_target", bus.pred_target, et);
    obs_hit = bus.hit;
    obs_way = bus.hit_way;
    obs_tgt = bus.pred_target;
    @(posedge clk);
    if (fl) clear_model();
    else if (init_left > 0) init_left--;
    else begin
      if (eh) ml[ls] = !ew;
      if (ch) ml[s] = cw;
      if (uv) begin
        pv = 1;
        ph = uh;
        pw = uw;
        pk = utk;
        ppc = upc;
        ptg = utg;
      end
    end
    @(negedge clk);
  endtask
  task automatic look(input logic [31:0] pc);
    step(0, 1, pc, 0, 0, 0, 0);
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    step(0, 0, 0, 1, pc, tgt, tk);
  endtask
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step(0, 1, 32'h2100, 1, 32'h100, 32'h999, 1);
      n++;
    end
    check(tag, n, 64);
  endtask
  task automatic do_reset();
    rst = 1;
    step_idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.ready, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_target", bus.pred_target, 0);
    rst = 0;
    clear_model();
  endtask
  task automatic step_idle_inputs();
    bus.flush = 0;
    bus.lookup_read = 1;
    bus.lookup_pc = 32'h100;
    bus.upd_valid = 0;
    bus.upd_pc = 0;
    bus.upd_target = 0;
    bus.upd_taken = 0;
    bus.upd_hit = 0;
    bus.upd_way = 0;
  endtask
  initial begin
    logic [31:0] a, b;
    tests = 0;
    fails = 0;
    do_reset();
    wait_ready("init_len");
    look(32'h100);
    check("dropped_in_init", obs_hit, 0);
    upd(32'h100, 32'h200, 1);
    look(32'h100);
    check("alloc_hit", obs_hit, 1);
    check("alloc_way", obs_way, 0);
    check("alloc_target", obs_tgt, 32'h200);
    upd(32'h100, 32'h300, 1);
    look(32'h100);
    check("bypass_target", obs_tgt, 32'h300);
    upd(32'h1100, 32'h1200, 1);
    look(32'h1100);
    check("second_way", obs_way, 1);
    look(32'h100);
    upd(32'h2100, 32'h2200, 1);
    look(32'h1100);
    check("evicted", obs_hit, 0);
    look(32'h2100);
    check("victim_way", obs_way, 1);
    check("victim_target", obs_tgt, 32'h2200);
    upd(32'h100, 32'h0, 0);
    look(32'h100);
    check("not_taken_inval", obs_hit, 0);
    step(1, 1, 32'h2100, 0, 0, 0, 0);
    wait_ready("flush_len");
    look(32'h2100);
    check("flushed", obs_hit, 0);
    upd(32'h2100, 32'h42, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) look(32'h2100);
    step(1, 0, 0, 0, 0, 0, 0);
    wait_ready("reflush_len");
    for (int i = 0; i < 1500; i++) begin
      a = {20'h0, 4'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), 2'b00};
      b = {20'h0, 4'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), 2'b00};
      step($urandom_range(0, 399) == 0, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
           b, $urandom, $urandom_range(0, 9) < 7);
    end
    do_reset();
    wait_ready("rerst_len");
    look(32'h2100);
    check("rerst_miss", obs_hit, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
